// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input handshake and instruction-memory write port
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [15:0]           mem_wdata;

    modport master (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: parses a checksummed byte frame and writes 16-bit words into instruction memory
module imem_loader #(
    parameter int         ADDR_WIDTH = 10,
    parameter int         MAX_WORDS  = 1024,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    imem_loader_if.master       bus,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_error,
    output logic                o_cpu_hold,
    output logic [ADDR_WIDTH:0] o_words_loaded
);
    typedef enum logic [3:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_WRITE, S_CHECK, S_DONE, S_ERROR
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [15:0]           r_len;
    logic [7:0]            r_hi;
    logic [7:0]            r_chk;
    logic [ADDR_WIDTH:0]   r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [15:0]           r_wdata;
    logic                  w_rx;
    logic                  w_fire;
    logic [15:0]           w_len;
    logic                  w_last;

    assign w_rx   = (r_state == S_IDLE) || (r_state == S_LEN_HI) || (r_state == S_LEN_LO) ||
                    (r_state == S_DATA_HI) || (r_state == S_DATA_LO) || (r_state == S_CHECK);
    assign w_fire = bus.in_valid && bus.in_ready;
    assign w_len  = {r_len[15:8], bus.in_data};
    assign w_last = (16'(r_cnt) + 16'd1) == r_len;

    assign bus.in_ready  = w_rx && !i_start;
    assign bus.mem_we    = (r_state == S_WRITE) && !i_start;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;

    assign o_busy         = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ERROR);
    assign o_done         = r_state == S_DONE;
    assign o_error        = r_state == S_ERROR;
    assign o_cpu_hold     = !o_done;
    assign o_words_loaded = r_cnt;

    // Frame-parsing next state; start overrides everything and returns to IDLE
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    w_next = (w_fire && bus.in_data == SYNC_BYTE) ? S_LEN_HI : S_IDLE;
            S_LEN_HI:  w_next = w_fire ? S_LEN_LO : S_LEN_HI;
            S_LEN_LO:  w_next = !w_fire ? S_LEN_LO :
                                (w_len == 16'd0) ? S_CHECK :
                                (32'(w_len) > MAX_WORDS) ? S_ERROR : S_DATA_HI;
            S_DATA_HI: w_next = w_fire ? S_DATA_LO : S_DATA_HI;
            S_DATA_LO: w_next = w_fire ? S_WRITE : S_DATA_LO;
            S_WRITE:   w_next = w_last ? S_CHECK : S_DATA_HI;
            S_CHECK:   w_next = !w_fire ? S_CHECK : (bus.in_data == r_chk) ? S_DONE : S_ERROR;
            default:   w_next = r_state;
        endcase
        if (i_start) w_next = S_IDLE;
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Byte capture, checksum accumulation, word count and held memory-port values
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_len   <= '0;
            r_hi    <= '0;
            r_chk   <= '0;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (i_start) begin
            r_cnt <= '0;
        end else begin
            if (w_fire && r_state == S_IDLE && bus.in_data == SYNC_BYTE) r_chk <= '0;
            if (w_fire && (r_state == S_LEN_HI || r_state == S_LEN_LO ||
                           r_state == S_DATA_HI || r_state == S_DATA_LO)) r_chk <= r_chk ^ bus.in_data;
            if (w_fire && r_state == S_LEN_HI) r_len[15:8] <= bus.in_data;
            if (w_fire && r_state == S_LEN_LO) r_len[7:0] <= bus.in_data;
            if (w_fire && r_state == S_DATA_HI) r_hi <= bus.in_data;
            if (w_fire && r_state == S_DATA_LO) begin
                r_wdata <= {r_hi, bus.in_data};
                r_addr  <= r_cnt[ADDR_WIDTH-1:0];
            end
            if (r_state == S_WRITE) r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed frames with a write scoreboard checked by an independent monitor
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, error, cpu_hold;
    logic [10:0] words_loaded;
    int          n_pass = 0;
    int          n_total = 0;
    logic [25:0] sb[$];
    logic [7:0]  fr[$];
    logic [15:0] good_w[9] = '{16'h2009, 16'h200A, 16'h012A, 16'h012B, 16'h014B,
                               16'h014B, 16'h016A, 16'h018B, 16'hFFFF};

    imem_loader_if #(.ADDR_WIDTH(10)) bus ();

    imem_loader #(.ADDR_WIDTH(10), .MAX_WORDS(1024), .SYNC_BYTE(8'hA5)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_start        (start),
        .bus            (bus),
        .o_busy         (busy),
        .o_done         (done),
        .o_error        (error),
        .o_cpu_hold     (cpu_hold),
        .o_words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every write must match the head of the scoreboard; in_ready is low only in WRITE
    always @(negedge clk) begin
        if (rst_n && bus.mem_we) begin
            if (sb.size() == 0) begin
                check("unexpected_we", {22'd0, bus.mem_addr}, 32'hFFFF_FFFF);
            end else begin
                logic [25:0] e;
                e = sb.pop_front();
                check("wr_addr", {22'd0, bus.mem_addr}, {22'd0, e[25:16]});
                check("wr_data", {16'd0, bus.mem_wdata}, {16'd0, e[15:0]});
            end
            check("ready_in_write", {31'd0, bus.in_ready}, 32'd0);
        end else if (rst_n && busy && !bus.in_ready && !start) begin
            check("ready_low_outside_write", 32'd0, 32'd1);
        end
    end

    task automatic exp_w(input int a, input logic [15:0] d);
        sb.push_back({10'(a), d});
    endtask

    // Entered and left just after a rising edge
    task automatic send(input logic [7:0] b, input bit rnd);
        logic rdy;
        int   n;
        if (rnd) begin
            repeat ($urandom_range(0, 2)) begin
                bus.in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        n = 0;
        do begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 64);
        if (!rdy) check("handshake_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_frame(input bit rnd);
        foreach (fr[i]) send(fr[i], rnd);
    endtask

    task automatic end_state(input logic d, input logic e, input int w);
        @(negedge clk);
        check("done", {31'd0, done}, {31'd0, d});
        check("error", {31'd0, error}, {31'd0, e});
        check("cpu_hold", {31'd0, cpu_hold}, {31'd0, ~d});
        check("busy", {31'd0, busy}, 32'd0);
        check("words_loaded", {21'd0, words_loaded}, 32'(w));
        check("writes_pending", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("start_done", {31'd0, done}, 32'd0);
        check("start_error", {31'd0, error}, 32'd0);
        check("start_words", {21'd0, words_loaded}, 32'd0);
        check("start_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset();
        check("rst_we", {31'd0, bus.mem_we}, 32'd0);
        check("rst_addr", {22'd0, bus.mem_addr}, 32'd0);
        check("rst_wdata", {16'd0, bus.mem_wdata}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check("rst_words", {21'd0, words_loaded}, 32'd0);
        check("rst_ready", {31'd0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Good 9-word image
        for (int i = 0; i < 9; i++) exp_w(i, good_w[i]);
        fr = '{8'hA5, 8'h00, 8'h09, 8'h20, 8'h09, 8'h20, 8'h0A, 8'h01, 8'h2A, 8'h01, 8'h2B,
               8'h01, 8'h4B, 8'h01, 8'h4B, 8'h01, 8'h6A, 8'h01, 8'h8B, 8'hFF, 8'hFF, 8'hEA};
        send_frame(1'b0);
        end_state(1'b1, 1'b0, 9);
        restart();

        // Same image, wrong checksum byte
        for (int i = 0; i < 9; i++) exp_w(i, good_w[i]);
        fr[21] = 8'hEB;
        send_frame(1'b0);
        end_state(1'b0, 1'b1, 9);
        restart();

        // Leading garbage, then an empty frame
        fr = '{8'h00, 8'h3C, 8'hA5, 8'h00, 8'h00, 8'h00};
        send_frame(1'b0);
        end_state(1'b1, 1'b0, 0);
        restart();

        // LEN = 1025 is rejected right after LEN_LO
        fr = '{8'hA5, 8'h04, 8'h01};
        send_frame(1'b0);
        @(negedge clk);
        check("oversize_error", {31'd0, error}, 32'd1);
        check("oversize_ready", {31'd0, bus.in_ready}, 32'd0);
        check("oversize_words", {21'd0, words_loaded}, 32'd0);
        @(posedge clk);
        #1;
        restart();

        // Two-word frame with random source stalls; CHK = 00^02^12^34^AB^CD = 42
        exp_w(0, 16'h1234);
        exp_w(1, 16'hABCD);
        fr = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        send_frame(1'b1);
        end_state(1'b1, 1'b0, 2);
        restart();

        // start on the WRITE cycle of word 1 suppresses that write
        exp_w(0, 16'h1234);
        fr = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        send_frame(1'b0);
        start = 1'b1;
        @(negedge clk);
        check("abort_we", {31'd0, bus.mem_we}, 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_words", {21'd0, words_loaded}, 32'd0);
        check("abort_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        exp_w(0, 16'h1234);
        exp_w(1, 16'hABCD);
        fr = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        send_frame(1'b0);
        end_state(1'b1, 1'b0, 2);
        restart();

        // Reset pulse on the WRITE cycle of word 1
        exp_w(0, 16'h1234);
        fr = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        send_frame(1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_w(0, 16'h1234);
        exp_w(1, 16'hABCD);
        fr = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        send_frame(1'b0);
        end_state(1'b1, 1'b0, 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
